frame_bram_arbiter: RTL and testbench

Shares the single port of the binary frame BRAM (480 rows × 640-bit words) among three requesters: capture writer, morphology engine and display reader. Ownership is granted round-robin with a bounded burst length, so no requester can starve the others. The arbiter drives BRAM `ena`/`wea`/`addra`/`dina` and routes the registered `douta` back to whichever requester issued each read. It sits between the requesters and the frame BRAM, replacing direct BRAM drive by any single engine.

---
 rtl/frame_mem_pkg.sv | 34 +++
 rtl/frame_bram_arbiter_rr_pick3.sv | 43 ++++
 rtl/frame_bram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_frame_bram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_mem_pkg.sv
// Purpose: shared frame-memory geometry, requester ids and arbiter types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: frame size constants, requester index constants, req_id_t,
//           arbiter state enum, read-tag struct, round-robin successor helper.
package frame_mem_pkg;

  localparam int FRAME_W    = 640;
  localparam int FRAME_H    = 480;
  localparam int ROW_ADDR_W = 9;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_CAP   = 2'd0;
  localparam req_id_t REQ_MORPH = 2'd1;
  localparam req_id_t REQ_DISP  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // One entry of the read-return pipeline: which requester a read belongs to.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

  // Next requester in round-robin order (0 -> 1 -> 2 -> 0).
  function automatic req_id_t next_id(input req_id_t id);
    return (id >= REQ_DISP) ? REQ_CAP : req_id_t'(id + 2'd1);
  endfunction

endpackage

// File: rtl/frame_bram_arbiter_rr_pick3.sv
// Purpose: combinational 3-way round-robin picker.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to accept the pick.
// Ports: i_req   - request vector (index 0 = capture, 1 = morph, 2 = display)
//        i_last  - last owner; search starts at i_last+1
//        o_onehot- one-hot winner (all zero when nothing requests)
//        o_id    - winner id (don't-care when o_any is low)
//        o_any   - at least one request present
module rr_pick3
  import frame_mem_pkg::*;
(
  input  logic [2:0] i_req,
  input  req_id_t    i_last,
  output logic [2:0] o_onehot,
  output req_id_t    o_id,
  output logic       o_any
);

  req_id_t w_cand0;
  req_id_t w_cand1;
  req_id_t w_cand2;

  // Candidate order: last+1, last+2, last+3 (mod 3).
  assign w_cand0 = next_id(i_last);
  assign w_cand1 = next_id(w_cand0);
  assign w_cand2 = next_id(w_cand1);

  always_comb begin
    o_onehot = '0;
    o_any    = |i_req;
    if (i_req[w_cand0]) begin
      o_id = w_cand0;
    end else if (i_req[w_cand1]) begin
      o_id = w_cand1;
    end else begin
      o_id = w_cand2;
    end
    if (o_any) begin
      o_onehot[o_id] = 1'b1;
    end
  end

endmodule

// File: rtl/frame_bram_arbiter.sv
// Purpose: shares the single frame-BRAM port among capture, morph and display
//          with round-robin grants of bounded burst length.
// Latency: grant 1 cycle after req in IDLE; access reaches BRAM 1 cycle after
//          a beat; read data returns RD_LAT+2 cycles after the beat.
// Backpressure: a requester is stalled simply by not holding gnt; a beat only
//               happens when req & gnt, and ownership drops after MAX_BURST
//               beats or the first cycle the owner deasserts req.
// Ports: clk/rst (async, active-high); req/we/addr/wdata per requester
//        (requester k uses slice k); gnt one-hot ownership; rvalid/rdata read
//        return; bram_* drive the BRAM port, bram_douta is its read data.
module frame_bram_arbiter
  import frame_mem_pkg::*;
#(
  parameter int DATA_W    = FRAME_W,
  parameter int ADDR_W    = ROW_ADDR_W,
  parameter int RD_LAT    = 2,   // must be >= 1
  parameter int MAX_BURST = 16   // 1..255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_W-1:0]     bram_addra,
  output logic [DATA_W-1:0]     bram_dina,
  input  logic [DATA_W-1:0]     bram_douta
);

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  // ---------------------------------------------------------------- state
  arb_state_t           r_state;
  logic [2:0]           r_gnt;
  req_id_t              r_last;      // last/current owner (round-robin pointer)
  logic [7:0]           r_beat_cnt;  // beats already taken in this grant

  logic                 r_bram_ena;
  logic                 r_bram_wea;
  logic [ADDR_W-1:0]    r_bram_addra;
  logic [DATA_W-1:0]    r_bram_dina;

  rd_tag_t [RD_LAT:0]   r_tag;       // [0] = newest, [RD_LAT] = tail
  logic [2:0]           r_rvalid;
  logic [DATA_W-1:0]    r_rdata;

  // ---------------------------------------------------------------- picker
  logic [2:0]           w_pick_onehot;
  req_id_t              w_pick_id;
  logic                 w_pick_any;

  rr_pick3 u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_onehot (w_pick_onehot),
    .o_id     (w_pick_id),
    .o_any    (w_pick_any)
  );

  // ---------------------------------------------------------------- owner mux
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  rd_tag_t              w_new_tag;

  assign w_beat      = |(req & r_gnt);
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);

  // gnt is one-hot, so an AND-OR select picks the owner's request fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      if (r_gnt[k]) begin
        w_sel_we    = we[k];
        w_sel_addr  = addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Only read beats enter the return pipeline; the owner id travels with the
  // read so data returns to the issuer even after ownership has moved on.
  assign w_new_tag.vld = w_beat & ~w_sel_we;
  assign w_new_tag.id  = r_last;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_last     <= REQ_DISP;   // so capture has first priority out of reset
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state    <= ST_OWN;
            r_gnt      <= w_pick_onehot;
            r_last     <= w_pick_id;
            r_beat_cnt <= '0;
          end
        end
        ST_OWN: begin
          // Leaving always passes through one IDLE cycle, which is the dead
          // cycle that keeps two grants from ever overlapping.
          if (!w_beat || w_last_beat) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
          end else begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_gnt      <= '0;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- BRAM port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bram_ena   <= 1'b0;
      r_bram_wea   <= 1'b0;
      r_bram_addra <= '0;
      r_bram_dina  <= '0;
    end else begin
      r_bram_ena <= w_beat;
      r_bram_wea <= w_beat & w_sel_we;
      // Address/data hold on idle cycles to avoid needless toggling.
      if (w_beat) begin
        r_bram_addra <= w_sel_addr;
        r_bram_dina  <= w_sel_wdata;
      end
    end
  end

  // ---------------------------------------------------------------- read return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag    <= '0;       // in-flight reads are dropped
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_tag    <= {r_tag[RD_LAT-1:0], w_new_tag};
      r_rvalid <= '0;
      // Tail lines up with the cycle douta carries that read's data.
      if (r_tag[RD_LAT].vld) begin
        r_rvalid[r_tag[RD_LAT].id] <= 1'b1;
        r_rdata                    <= bram_douta;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign gnt        = r_gnt;
  assign rvalid     = r_rvalid;
  assign rdata      = r_rdata;
  assign bram_ena   = r_bram_ena;
  assign bram_wea   = r_bram_wea;
  assign bram_addra = r_bram_addra;
  assign bram_dina  = r_bram_dina;

endmodule

// File: tb/tb_frame_bram_arbiter.sv
// Purpose: self-checking bench for frame_bram_arbiter with a BRAM model,
//          a memory/ownership reference model and directed + random stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_bram_arbiter;
  import frame_mem_pkg::*;

  localparam int DATA_W    = 640;
  localparam int ADDR_W    = 9;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;
  localparam int RET_LAT   = RD_LAT + 2;   // beat cycle -> rvalid cycle

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                bram_ena;
  logic                bram_wea;
  logic [ADDR_W-1:0]   bram_addra;
  logic [DATA_W-1:0]   bram_dina;
  logic [DATA_W-1:0]   bram_douta;

  frame_bram_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- BRAM model
  logic [DATA_W-1:0] bram_mem [0:511];
  logic [DATA_W-1:0] rd_pipe  [RD_LAT];

  always @(posedge clk) begin
    if (bram_ena && bram_wea) bram_mem[bram_addra] <= bram_dina;
    if (bram_ena) rd_pipe[0] <= bram_mem[bram_addra];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_douta = rd_pipe[RD_LAT-1];

  // ---------------------------------------------------------------- checking
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_row(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_row();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Round-robin rule: search last+1, last+2, last+3 (mod 3).
  function automatic int rr_next(input int last, input logic [2:0] rq);
    for (int s = 1; s <= 3; s++) if (rq[(last+s)%3]) return (last+s)%3;
    return 0;
  endfunction

  function automatic int onehot_idx(input logic [2:0] v);
    for (int k = 0; k < 3; k++) if (v[k]) return k;
    return -1;
  endfunction

  // ---------------------------------------------------------------- reference model
  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  logic [DATA_W-1:0] ref_mem [0:511];
  rd_exp_t           rd_q [$];
  logic [2:0]        exp_gnt    = '0;
  logic [2:0]        prev_gnt   = '0;
  logic              prev_beat  = 1'b0;
  logic              prev_we    = 1'b0;
  logic [ADDR_W-1:0] prev_addr  = '0;
  logic [DATA_W-1:0] prev_wdata = '0;
  int                last_owner = 2;
  int                tenure     = 0;
  int                cyc        = 0;

  always @(negedge clk) begin
    int   k;
    logic beat;
    cyc++;
    if (rst) begin
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_ena", 32'(bram_ena), 32'd0);
      check("rst_wea", 32'(bram_wea), 32'd0);
      rd_q.delete();
      last_owner = 2;
      tenure     = 0;
      exp_gnt    = '0;
      prev_gnt   = '0;
      prev_beat  = 1'b0;
    end else begin
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("bram_ena", 32'(bram_ena), 32'(prev_beat));
      check("bram_wea", 32'(bram_wea), 32'(prev_beat && prev_we));
      if (prev_beat) begin
        check("bram_addra", 32'(bram_addra), 32'(prev_addr));
        if (prev_we) check_row("bram_dina", bram_dina, prev_wdata);
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        check("rvalid", 32'(rvalid), 32'(1 << rd_q[0].id));
        check_row("rdata", rdata, rd_q[0].data);
        void'(rd_q.pop_front());
      end else begin
        check("rvalid_idle", 32'(rvalid), 32'd0);
      end

      if (gnt != 3'b0 && prev_gnt == 3'b0) begin
        last_owner = onehot_idx(gnt);
        tenure     = 0;
      end
      k    = onehot_idx(gnt);
      beat = (k >= 0) && req[k];
      prev_beat = beat;
      if (beat) begin
        tenure++;
        prev_we    = we[k];
        prev_addr  = addr[k*ADDR_W +: ADDR_W];
        prev_wdata = wdata[k*DATA_W +: DATA_W];
        if (prev_we) ref_mem[prev_addr] = prev_wdata;
        else rd_q.push_back('{cyc + RET_LAT, k, ref_mem[prev_addr]});
      end
      if (gnt == 3'b0)
        exp_gnt = (req != 3'b0) ? 3'(1 << rr_next(last_owner, req)) : 3'b0;
      else
        exp_gnt = (beat && tenure < MAX_BURST) ? gnt : 3'b0;
      prev_gnt = gnt;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int k, input logic r, input logic w,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[k] = r;
    we[k]  = w;
    addr[k*ADDR_W +: ADDR_W]  = a;
    wdata[k*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [DATA_W-1:0] pat_a;
    logic [DATA_W-1:0] pat_b;
    logic [DATA_W-1:0] pat_c;
    logic [2:0]        exp;
    int                first_owner;

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int r = 0; r < 512; r++) begin
      pat_a       = rand_row();
      bram_mem[r] = pat_a;
      ref_mem[r]  = pat_a;
    end

    // Reset state.
    repeat (3) step();
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_ena", 32'(bram_ena), 32'd0);
    check_row("reset_rdata", rdata, '0);
    rst = 1'b0;
    repeat (2) step();

    // 1: single read of row 5 by requester 1.
    pat_a = ref_mem[5];
    set_rq(1, 1'b1, 1'b0, 9'd5, '0);
    step(); check("t1_gnt", 32'(gnt), 32'b010);
    step(); set_rq(1, 1'b0, 1'b0, 9'd5, '0);
    check("t1_ena_t1", 32'(bram_ena), 32'd1);
    check("t1_addr_t1", 32'(bram_addra), 32'd5);
    step(); check("t1_ena_t2", 32'(bram_ena), 32'd0);
    step(); check("t1_rvalid_t3", 32'(rvalid), 32'd0);
    step(); check("t1_rvalid_t4", 32'(rvalid), 32'b010);
    check_row("t1_rdata", rdata, pat_a);
    step();

    // 2: requester 0 writes row 7 then reads it back on the next beat.
    pat_b = rand_row();
    set_rq(0, 1'b1, 1'b1, 9'd7, pat_b);
    step(); check("t2_gnt", 32'(gnt), 32'b001);
    step(); set_rq(0, 1'b1, 1'b0, 9'd7, pat_b);
    check("t2_wea_write", 32'(bram_wea), 32'd1);
    step(); set_rq(0, 1'b0, 1'b0, 9'd7, '0);
    check("t2_wea_read", 32'(bram_wea), 32'd0);
    check("t2_ena_read", 32'(bram_ena), 32'd1);
    repeat (3) step();
    check("t2_rvalid", 32'(rvalid), 32'b001);
    check_row("t2_rdata", rdata, pat_b);
    repeat (2) step();

    // 3: three-way contention, random traffic. Requester 0 owned last, so 1 leads.
    first_owner = 1;
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) begin
        exp = ((i-1) % (MAX_BURST+1) == MAX_BURST) ? 3'b000
              : 3'(1 << ((first_owner + (i-1)/(MAX_BURST+1)) % 3));
        check("t3_gnt", 32'(gnt), 32'(exp));
      end
      for (int k = 0; k < 3; k++)
        set_rq(k, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, FRAME_H-1)), rand_row());
      step();
    end
    req = '0;
    repeat (RET_LAT + 2) step();

    // 4: owner 2 releases after 2 beats while requester 0 waits.
    set_rq(2, 1'b1, 1'b0, ADDR_W'($urandom_range(0, FRAME_H-1)), '0);
    step(); check("t4_gnt2", 32'(gnt), 32'b100);
    set_rq(0, 1'b1, 1'b0, 9'd3, '0);
    step();
    step(); set_rq(2, 1'b0, 1'b0, 9'd0, '0);
    check("t4_gnt2_hold", 32'(gnt), 32'b100);
    step(); check("t4_dead", 32'(gnt), 32'b000);
    step(); check("t4_gnt0", 32'(gnt), 32'b001);
    set_rq(0, 1'b0, 1'b0, 9'd3, '0);
    repeat (RET_LAT + 3) step();

    // 5: requester 1 reads through its last beat, then requester 2 takes over.
    pat_c = ref_mem[9];
    set_rq(1, 1'b1, 1'b0, 9'd9, '0);
    set_rq(2, 1'b1, 1'b1, 9'd11, rand_row());
    step(); check("t5_gnt1", 32'(gnt), 32'b010);
    repeat (4) step();
    set_rq(1, 1'b0, 1'b0, 9'd9, '0);
    check("t5_dead", 32'(gnt), 32'b000);
    for (int i = 0; i < 4; i++) begin
      check("t5_rvalid1", 32'(rvalid), 32'b010);
      check_row("t5_rdata", rdata, pat_c);
      if (i > 0) check("t5_gnt2", 32'(gnt), 32'b100);
      step();
    end
    set_rq(2, 1'b0, 1'b0, 9'd11, '0);
    repeat (RET_LAT + 3) step();

    // 6: reset one cycle after a read beat; pointer must return to 2.
    for (int k = 0; k < 3; k++)
      set_rq(k, 1'b1, 1'b0, ADDR_W'($urandom_range(0, FRAME_H-1)), '0);
    step(); check("t6_gnt0_pre", 32'(gnt), 32'b001);
    step();
    rst = 1'b1;
    #1;
    check("t6_async_gnt", 32'(gnt), 32'd0);
    check("t6_async_ena", 32'(bram_ena), 32'd0);
    check("t6_async_addr", 32'(bram_addra), 32'd0);
    check("t6_async_rvalid", 32'(rvalid), 32'd0);
    check_row("t6_async_rdata", rdata, '0);
    check_row("t6_async_dina", bram_dina, '0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t6_no_rvalid", 32'(rvalid), 32'd0);
      if (i == 1) check("t6_first_gnt", 32'(gnt), 32'b001);
      step();
    end
    req = '0;
    repeat (RET_LAT + 3) step();

    // 7: random traffic with sticky requests, checked by the reference model.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++)
        set_rq(k, req[k] ^ ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               ADDR_W'($urandom_range(0, FRAME_H-1)), rand_row());
      step();
    end
    req = '0;
    repeat (RET_LAT + 4) step();
    check("drain", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
